// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the MEMORY stage and the data-memory responder
// master: MEMORY stage side (drives req_*, observes req_ready, rsp_*, stall)
// slave : responder side (observes req_*, drives req_ready, rsp_*, stall)
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;
   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with WAIT_CYCLES wait states per access
// Ports: clk; reset (synchronous, active-high);
//   bus (dmem_responder_if.slave): req_valid/req_we/req_addr/req_wdata in,
//   req_ready/rsp_valid/rsp_rdata/rsp_err/stall out.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on rsp_err and skip the array.
module dmem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          state, state_n;
   logic [3:0]      cnt, cnt_n;
   logic            we_q, mis_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem [DEPTH];
   logic            accept, enter_resp, req_mis;
   logic            cur_we, cur_mis;
   logic [AW-1:0]   cur_idx;
   logic [31:0]     cur_wdata;
   logic            unused_ok;
`ifdef DMEM_ALIGN_CHECK_EN
   logic            err_q;
   assign req_mis   = bus.req_addr[1:0] != 2'b00;
   assign unused_ok = ^bus.req_addr[31:AW+2];
`else
   assign req_mis   = 1'b0;
   assign unused_ok = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif
   always_comb begin
      accept  = state == IDLE && bus.req_valid;
      state_n = state;
      cnt_n   = cnt;
      if (accept) begin
         state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
         cnt_n   = CNT_INIT;
      end else if (state == WAIT) begin
         state_n = cnt == 4'd0 ? RESP : WAIT;
         cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end else if (state == RESP) begin
         state_n = IDLE;
      end
   end
   // With zero wait states the array access happens on the accept edge, so use the live request
   assign cur_we     = state == IDLE ? bus.req_we : we_q;
   assign cur_mis    = state == IDLE ? req_mis : mis_q;
   assign cur_idx    = state == IDLE ? bus.req_addr[AW+1:2] : idx_q;
   assign cur_wdata  = state == IDLE ? bus.req_wdata : wdata_q;
   assign enter_resp = state_n == RESP;
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rdata_q <= enter_resp && !cur_we && !cur_mis ? mem[cur_idx] : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         mis_q   <= req_mis;
         idx_q   <= bus.req_addr[AW+1:2];
         wdata_q <= bus.req_wdata;
      end
   end
   // Reset on the entry edge into RESP discards the pending store
   always_ff @(posedge clk) begin
      if (!reset && enter_resp && cur_we && !cur_mis) mem[cur_idx] <= cur_wdata;
   end
`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else err_q <= enter_resp && cur_mis;
   end
   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif
   assign bus.req_ready = state == IDLE;
   assign bus.rsp_valid = state == RESP;
   assign bus.rsp_rdata = rdata_q;
   assign bus.stall     = state == WAIT || (state == IDLE && bus.req_valid);
endmodule
